// File: rtl/adc_block_avg.sv
// Decimating block averager for the two-channel signed ADC stream.
// Sums 2^cfg samples per channel and emits the floor mean with a one-cycle
// valid strobe. Channels A and B share the window counter and exponent.
module adc_block_avg #(
  parameter int bits     = 14,
  parameter int max_log2 = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [3:0]             dec_log2,
  input  logic signed [bits-1:0] adc_a_i,
  input  logic signed [bits-1:0] adc_b_i,
  output logic signed [bits-1:0] avg_a_o,
  output logic signed [bits-1:0] avg_b_o,
  output logic                   valid_o
);

  // 2^max_log2 full-scale samples fit without overflow.
  localparam int acc_w = bits + max_log2;
  localparam int cfg_w = $clog2(max_log2 + 1);
  localparam int cnt_w = (max_log2 > 0) ? max_log2 : 1;

  logic signed [acc_w-1:0] acc_a;
  logic signed [acc_w-1:0] acc_b;
  logic        [cnt_w-1:0] cnt;
  logic        [cfg_w-1:0] cfg;
  // Set by reset: the first edge after release uses and latches the
  // requested exponent directly, since no window start has latched it yet.
  logic                    cfg_pend;

  logic        [cfg_w-1:0] cfg_req;
  logic        [cfg_w-1:0] cfg_eff;
  logic        [max_log2:0] last_idx;
  logic                    last_smp;
  logic signed [acc_w-1:0] sum_a;
  logic signed [acc_w-1:0] sum_b;

  // Clamp the requested exponent, pick the active one, and form the
  // running sums including the sample on this edge.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (defaults
    // here first) so no latch can be inferred.
    cfg_req  = cfg_w'(dec_log2);
    if (int'(dec_log2) > max_log2) cfg_req = cfg_w'(max_log2);
    cfg_eff  = cfg_pend ? cfg_req : cfg;
    last_idx = ((max_log2 + 1)'(1) << cfg_eff) - (max_log2 + 1)'(1);
    last_smp = ({1'b0, cnt} == (max_log2 + 1)'(last_idx));
    sum_a    = acc_a + acc_w'(adc_a_i);
    sum_b    = acc_b + acc_w'(adc_b_i);
  end

  // Window accumulation, strobe generation and exponent relatching.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    if (!rst) begin
      acc_a    <= '0;
      acc_b    <= '0;
      cnt      <= '0;
      cfg      <= '0;
      cfg_pend <= 1'b1;
      avg_a_o  <= '0;
      avg_b_o  <= '0;
      valid_o  <= 1'b0;
    end else begin
      cfg_pend <= 1'b0;
      valid_o  <= 1'b0;
      if (cfg_pend) cfg <= cfg_req;
      if (clr) begin
        // Window restart: the sample on this edge is dropped, outputs hold.
        acc_a <= '0;
        acc_b <= '0;
        cnt   <= '0;
        cfg   <= cfg_req;
      end else if (en) begin
        if (last_smp) begin
          avg_a_o <= bits'(sum_a >>> cfg_eff);
          avg_b_o <= bits'(sum_b >>> cfg_eff);
          valid_o <= 1'b1;
          acc_a   <= '0;
          acc_b   <= '0;
          cnt     <= '0;
          cfg     <= cfg_req;
        end else begin
          acc_a <= sum_a;
          acc_b <= sum_b;
          cnt   <= cnt + cnt_w'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_block_avg.sv
// Directed bench for adc_block_avg: a vector table for the single-edge
// behaviour plus hand-written sequences for clamping, long windows and
// mid-window reset.
module tb_adc_block_avg;

  localparam int bits     = 14;
  localparam int max_log2 = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   en  = 1'b0;
  logic                   clr = 1'b0;
  logic [3:0]             dec_log2 = 4'd2;
  logic signed [bits-1:0] adc_a_i = '0;
  logic signed [bits-1:0] adc_b_i = '0;
  logic signed [bits-1:0] avg_a_o;
  logic signed [bits-1:0] avg_b_o;
  logic                   valid_o;

  adc_block_avg #(.bits(bits), .max_log2(max_log2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .dec_log2 (dec_log2),
    .adc_a_i  (adc_a_i),
    .adc_b_i  (adc_b_i),
    .avg_a_o  (avg_a_o),
    .avg_b_o  (avg_b_o),
    .valid_o  (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] dec;
    int         a;
    int         b;
    int         ev;
    int         ea;
    int         eb;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic c, input logic [3:0] d,
                     input int a, input int b,
                     input int ev, input int ea, input int eb);
    vec_t v;
    v.en = e; v.clr = c; v.dec = d; v.a = a; v.b = b;
    v.ev = ev; v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic e, input logic c, input logic [3:0] d,
                       input int a, input int b);
    @(negedge clk);
    en       = e;
    clr      = c;
    dec_log2 = d;
    adc_a_i  = bits'(a);
    adc_b_i  = bits'(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int ev, input int ea, input int eb);
    check({tag, " valid"}, int'(valid_o), ev);
    check({tag, " avg_a"}, int'(avg_a_o), ea);
    check({tag, " avg_b"}, int'(avg_b_o), eb);
  endtask

  initial begin
    int bad_valid;

    // Reset state.
    #12;
    check_out("reset", 0, 0, 0);

    // Basic window D=2, then a gap-free second window that requests D=1.
    add(1, 0, 2, 100, -100, 0, 0, 0);
    add(1, 0, 2, 200, -100, 0, 0, 0);
    add(1, 0, 2, 300, -100, 0, 0, 0);
    add(1, 0, 2, 400, -100, 1, 250, -100);
    add(1, 0, 2, 8, 0, 0, 250, -100);
    add(1, 0, 2, 8, 0, 0, 250, -100);
    add(1, 0, 2, 8, 0, 0, 250, -100);
    add(1, 0, 1, 8, 0, 1, 8, 0);
    // D=1: floor rounding of a negative sum; requests D=2 on the close.
    add(1, 0, 1, -1, 5, 0, 8, 0);
    add(1, 0, 2, -2, 6, 1, -2, 5);
    // en pattern 1,0,1,1,0,0,1 with junk on idle cycles.
    add(1, 0, 2, 4, -3, 0, -2, 5);
    add(0, 0, 2, 999, 999, 0, -2, 5);
    add(1, 0, 2, 4, -3, 0, -2, 5);
    add(1, 0, 2, 4, -3, 0, -2, 5);
    add(0, 0, 2, 999, 999, 0, -2, 5);
    add(0, 0, 2, 999, 999, 0, -2, 5);
    add(1, 0, 2, 4, -3, 1, 4, -3);
    // dec 2->0 mid-window: window still closes after 4 samples.
    add(1, 0, 2, 1, 0, 0, 4, -3);
    add(1, 0, 2, 2, 0, 0, 4, -3);
    add(1, 0, 0, 3, 0, 0, 4, -3);
    add(1, 0, 0, 6, 0, 1, 3, 0);
    add(1, 0, 0, -7, 7, 1, -7, 7);
    add(1, 0, 2, 13, -13, 1, 13, -13);
    add(0, 0, 2, 0, 0, 0, 13, -13);
    // clr after 3 samples of 1000; the clr-edge sample is dropped too.
    add(1, 0, 2, 1000, 1000, 0, 13, -13);
    add(1, 0, 2, 1000, 1000, 0, 13, -13);
    add(1, 0, 2, 1000, 1000, 0, 13, -13);
    add(1, 1, 2, 1000, 1000, 0, 13, -13);
    add(1, 0, 2, 20, -20, 0, 13, -13);
    add(1, 0, 2, 20, -20, 0, 13, -13);
    add(1, 0, 2, 20, -20, 0, 13, -13);
    add(1, 0, 2, 20, -20, 1, 20, -20);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].dec, vecs[i].a, vecs[i].b);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].eb);
    end

    // dec_log2=15 clamps to a 1024-sample window; restart via clr.
    drive(1, 1, 15, 0, 0);
    step();
    check("clamp clr valid", int'(valid_o), 0);
    bad_valid = 0;
    for (int i = 0; i < 1023; i++) begin
      drive(1, 0, 15, -8192, 8191);
      step();
      if (valid_o !== 1'b0) bad_valid++;
    end
    check("clamp early strobes", bad_valid, 0);
    drive(1, 0, 10, -8192, 8191);
    step();
    check_out("clamp close", 1, -8192, 8191);

    // dec_log2=10 full-scale window, swapped extremes.
    bad_valid = 0;
    for (int i = 0; i < 1023; i++) begin
      drive(1, 0, 10, 8191, -8192);
      step();
      if (valid_o !== 1'b0) bad_valid++;
    end
    check("d10 early strobes", bad_valid, 0);
    drive(1, 0, 2, 8191, -8192);
    step();
    check_out("d10 close", 1, 8191, -8192);

    // Async reset mid-window: outputs clear at once, partial window lost.
    drive(1, 0, 2, 100, 100);
    step();
    drive(1, 0, 2, 100, 100);
    step();
    en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_out("async rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2, 40, -40);
      step();
      check_out($sformatf("post rst s%0d", i), 0, 0, 0);
    end
    drive(1, 0, 2, 40, -40);
    step();
    check_out("post rst close", 1, 40, -40);
    drive(0, 0, 2, 0, 0);
    step();
    check_out("post rst hold", 0, 40, -40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
